// File: rtl/espiro_pkg.sv
// Shared definitions for the spirometry test controller: FSM states, severity
// class codes, classification thresholds and divider widths.
package espiro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ACQ     = 3'd3,
        ST_DIVIDE  = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [1:0] CLS_NORMAL   = 2'd0;
    localparam logic [1:0] CLS_MODERATE = 2'd1;
    localparam logic [1:0] CLS_SEVERE   = 2'd2;
    localparam logic [1:0] CLS_INVALID  = 2'd3;

    localparam int PCT_W      = 8;
    localparam int DIVIDEND_W = 19;
    localparam int DIVISOR_W  = 10;
    localparam int PCT_SCALE  = 100;

    localparam logic [PCT_W-1:0] THR_NORMAL   = 8'd80;
    localparam logic [PCT_W-1:0] THR_MODERATE = 8'd60;

    function automatic logic [1:0] clase_of(input logic [PCT_W-1:0] pct);
        if (pct >= THR_NORMAL) begin
            return CLS_NORMAL;
        end else if (pct >= THR_MODERATE) begin
            return CLS_MODERATE;
        end
        return CLS_SEVERE;
    endfunction

endpackage

// File: rtl/espiro_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, with the quotient
// saturated to the percentage width. start_i restarts it even when busy.
module espiro_div_seq
    import espiro_pkg::*;
(
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [PCT_W-1:0]      quot_o
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [PCT_W-1:0]      quot_q, quot_d;

    logic [DIVISOR_W:0]    rem_sh;
    logic [DIVISOR_W:0]    rem_diff;
    logic                  qbit;

    function automatic logic [PCT_W-1:0] sat_quot(input logic [DIVIDEND_W-1:0] q);
        if (|q[DIVIDEND_W-1:PCT_W]) begin
            return '1;
        end
        return q[PCT_W-1:0];
    endfunction

    always_comb begin
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        quot_d   = quot_q;
        qbit     = 1'b0;
        // Dividend bits are shifted out at the top while quotient bits fill the bottom.
        rem_sh   = {rem_q, dvd_q[DIVIDEND_W-1]};
        rem_diff = rem_sh - {1'b0, dsr_q};

        if (start_i) begin
            rem_d  = '0;
            dvd_d  = dividend_i;
            dsr_d  = divisor_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (rem_sh >= {1'b0, dsr_q}) begin
                rem_d = rem_diff[DIVISOR_W-1:0];
                qbit  = 1'b1;
            end else begin
                rem_d = rem_sh[DIVISOR_W-1:0];
            end
            dvd_d = {dvd_q[DIVIDEND_W-2:0], qbit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                quot_d = sat_quot(dvd_d);
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quot_q <= '0;
        end else begin
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            quot_q <= quot_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = quot_q;

endmodule

// File: rtl/espiro_test_ctrl.sv
// Spirometry test sequencer: age latch, CVP lookup handshake, flow integration,
// end-of-exhalation detection and %-of-predicted classification.
// Optional peak-flow tracking is enabled by defining ESPIRO_PEAK_FLOW_EN.
module espiro_test_ctrl
    import espiro_pkg::*;
#(
    parameter int END_ZERO = 8,
    parameter int MAX_SAMP = 600,
    parameter int VOL_W    = 12
) (
    input  logic                 iClk,
    input  logic                 iReset_n,
    input  logic                 iStart,
    input  logic                 iAbort,
    input  logic [7:0]           ivEdad,
    input  logic                 iSampleValid,
    input  logic [7:0]           ivFlow,
    output logic [7:0]           ovEdad,
    output logic                 oCVP_CE,
    input  logic [9:0]           ivCVP,
    output logic [VOL_W-1:0]     ovVolumen,
    output logic [PCT_W-1:0]     ovPorcentaje,
    output logic [1:0]           ovClase,
    output logic [7:0]           ovPicoFlujo,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int SW = $clog2(MAX_SAMP + 1);
    localparam int ZW = $clog2(END_ZERO + 1);

    state_e               state_q, state_d;
    logic [7:0]           edad_q, edad_d;
    logic [DIVISOR_W-1:0] cvp_q, cvp_d;
    logic [VOL_W-1:0]     vol_q, vol_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [ZW-1:0]        zero_q, zero_d;
    logic                 seen_q, seen_d;
    logic [PCT_W-1:0]     pct_q, pct_d;
    logic [1:0]           clase_q, clase_d;
    logic                 div_started_q, div_started_d;

    logic                  start_acc;
    logic                  abort_acc;
    logic                  div_start;
    logic                  div_busy;
    logic                  div_done;
    logic [PCT_W-1:0]      div_quot;
    logic [DIVIDEND_W-1:0] dividend;

    function automatic logic [VOL_W-1:0] sat_add(input logic [VOL_W-1:0] a,
                                                 input logic [7:0]       b);
        logic [VOL_W:0] s;
        s = {1'b0, a} + (VOL_W + 1)'(b);
        if (s[VOL_W]) begin
            return '1;
        end
        return s[VOL_W-1:0];
    endfunction

    assign start_acc = (state_q == ST_IDLE) && iStart && !iAbort;
    assign abort_acc = (state_q != ST_IDLE) && iAbort;
    assign dividend  = DIVIDEND_W'(vol_q) * DIVIDEND_W'(PCT_SCALE);

    espiro_div_seq u_div (
        .iClk       (iClk),
        .iReset_n   (iReset_n),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (cvp_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );

    always_comb begin
        state_d       = state_q;
        edad_d        = edad_q;
        cvp_d         = cvp_q;
        vol_d         = vol_q;
        samp_d        = samp_q;
        zero_d        = zero_q;
        seen_d        = seen_q;
        pct_d         = pct_q;
        clase_d       = clase_q;
        div_started_d = div_started_q;
        div_start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    edad_d        = ivEdad;
                    vol_d         = '0;
                    samp_d        = '0;
                    zero_d        = '0;
                    seen_d        = 1'b0;
                    pct_d         = '0;
                    clase_d       = CLS_NORMAL;
                    div_started_d = 1'b0;
                    state_d       = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                cvp_d   = ivCVP;
                state_d = ST_ACQ;
            end
            ST_ACQ: begin
                if (iSampleValid) begin
                    vol_d  = sat_add(vol_q, ivFlow);
                    samp_d = samp_q + 1'b1;
                    if (ivFlow != 8'd0) begin
                        seen_d = 1'b1;
                        zero_d = '0;
                    end else if (seen_q) begin
                        zero_d = zero_q + 1'b1;
                    end
                    // Timeout and end-of-exhalation on the same sample both land in DIVIDE.
                    if ((zero_d == ZW'(END_ZERO)) || (samp_d == SW'(MAX_SAMP))) begin
                        state_d = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                if (!seen_q || (cvp_q == '0)) begin
                    pct_d   = '0;
                    clase_d = CLS_INVALID;
                    state_d = ST_DONE;
                end else if (!div_started_q) begin
                    div_start     = 1'b1;
                    div_started_d = 1'b1;
                end else if (div_done && !div_busy) begin
                    pct_d   = div_quot;
                    clase_d = clase_of(div_quot);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_acc) begin
            state_d = ST_IDLE;
            vol_d   = '0;
            pct_d   = '0;
            clase_d = CLS_NORMAL;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q       <= ST_IDLE;
            edad_q        <= '0;
            cvp_q         <= '0;
            vol_q         <= '0;
            samp_q        <= '0;
            zero_q        <= '0;
            seen_q        <= 1'b0;
            pct_q         <= '0;
            clase_q       <= '0;
            div_started_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            edad_q        <= edad_d;
            cvp_q         <= cvp_d;
            vol_q         <= vol_d;
            samp_q        <= samp_d;
            zero_q        <= zero_d;
            seen_q        <= seen_d;
            pct_q         <= pct_d;
            clase_q       <= clase_d;
            div_started_q <= div_started_d;
        end
    end

`ifdef ESPIRO_PEAK_FLOW_EN
    logic [7:0] peak_q;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            peak_q <= '0;
        end else if (start_acc || abort_acc) begin
            peak_q <= '0;
        end else if ((state_q == ST_ACQ) && iSampleValid && (ivFlow > peak_q)) begin
            peak_q <= ivFlow;
        end
    end

    assign ovPicoFlujo = peak_q;
`else
    assign ovPicoFlujo = '0;
`endif

    assign ovEdad       = edad_q;
    assign oCVP_CE      = (state_q == ST_LOOKUP);
    assign ovVolumen    = vol_q;
    assign ovPorcentaje = pct_q;
    assign ovClase      = clase_q;
    assign oBusy        = (state_q != ST_IDLE);
    assign oDone        = (state_q == ST_DONE);

endmodule

// File: tb/tb_espiro_test_ctrl.sv
// Bench for espiro_test_ctrl: directed and randomized tests scored against a
// sample-list model of the test; honours ESPIRO_PEAK_FLOW_EN for the peak output.
module tb_espiro_test_ctrl;

    localparam int END_ZERO = 8;
    localparam int MAX_SAMP = 600;
    localparam int VOL_MAX  = 4095;

    typedef struct packed {
        int vol;
        int pct;
        int cls;
        int peak;
        int edad;
    } res_t;

    logic        iClk, iReset_n, iStart, iAbort, iSampleValid;
    logic [7:0]  ivEdad, ivFlow;
    logic [7:0]  ovEdad;
    logic        oCVP_CE;
    logic [9:0]  ivCVP;
    logic [11:0] ovVolumen;
    logic [7:0]  ovPorcentaje;
    logic [1:0]  ovClase;
    logic [7:0]  ovPicoFlujo;
    logic        oBusy, oDone;

    int   n_cmp, n_bad, done_cnt, ce_cnt;
    bit   exp_valid;
    res_t exp_r, hold_r;

    espiro_test_ctrl dut (
        .iClk         (iClk),
        .iReset_n     (iReset_n),
        .iStart       (iStart),
        .iAbort       (iAbort),
        .ivEdad       (ivEdad),
        .iSampleValid (iSampleValid),
        .ivFlow       (ivFlow),
        .ovEdad       (ovEdad),
        .oCVP_CE      (oCVP_CE),
        .ivCVP        (ivCVP),
        .ovVolumen    (ovVolumen),
        .ovPorcentaje (ovPorcentaje),
        .ovClase      (ovClase),
        .ovPicoFlujo  (ovPicoFlujo),
        .oBusy        (oBusy),
        .oDone        (oDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [9:0] cvp_of(input int age);
        case (age)
            25:      return 10'd402;
            70:      return 10'd150;
            18:      return 10'd380;
            5:       return 10'd150;
            99:      return 10'd0;
            default: return 10'(120 + age * 4);
        endcase
    endfunction

    // Predicted-CVP lookup stand-in: registered, answer valid the cycle after CE.
    always @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) ivCVP <= '0;
        else if (oCVP_CE) ivCVP <= cvp_of(int'(ovEdad));
    end

    function automatic res_t model(input int age, input int flows[$]);
        res_t r;
        int vol = 0, samp = 0, zeros = 0, pk = 0, cvp;
        bit seen = 0;
        cvp = int'(cvp_of(age));
        for (int i = 0; i < flows.size(); i++) begin
            vol = (vol + flows[i] > VOL_MAX) ? VOL_MAX : vol + flows[i];
            samp++;
            if (flows[i] != 0) begin
                seen = 1;
                zeros = 0;
            end else if (seen) begin
                zeros++;
            end
            if (flows[i] > pk) pk = flows[i];
            if (zeros == END_ZERO || samp == MAX_SAMP) break;
        end
        r.vol  = vol;
        r.edad = age;
        if (!seen || cvp == 0) begin
            r.pct = 0;
            r.cls = 3;
        end else begin
            r.pct = (vol * 100) / cvp;
            if (r.pct > 255) r.pct = 255;
            r.cls = (r.pct >= 80) ? 0 : (r.pct >= 60) ? 1 : 2;
        end
`ifdef ESPIRO_PEAK_FLOW_EN
        r.peak = pk;
`else
        r.peak = 0;
`endif
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle scoring: results at oDone, and held results whenever idle.
    task automatic cmp_cycle();
        if (!iReset_n) return;
        if (oCVP_CE) ce_cnt++;
        if (oDone) begin
            done_cnt++;
            check("done_expected", int'(exp_valid), 1);
            check("done_vol", int'(ovVolumen), exp_r.vol);
            check("done_pct", int'(ovPorcentaje), exp_r.pct);
            check("done_cls", int'(ovClase), exp_r.cls);
            check("done_peak", int'(ovPicoFlujo), exp_r.peak);
            check("done_edad", int'(ovEdad), exp_r.edad);
            check("done_busy", int'(oBusy), 1);
            hold_r    = exp_r;
            exp_valid = 0;
        end else if (!oBusy) begin
            check("idle_vol", int'(ovVolumen), hold_r.vol);
            check("idle_pct", int'(ovPorcentaje), hold_r.pct);
            check("idle_cls", int'(ovClase), hold_r.cls);
            check("idle_peak", int'(ovPicoFlujo), hold_r.peak);
        end
    endtask

    task automatic tick();
        @(negedge iClk);
        cmp_cycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic start_test(input int age);
        ivEdad = 8'(age);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send(input int f, input int gap);
        iSampleValid = 1'b1;
        ivFlow       = 8'(f);
        tick();
        iSampleValid = 1'b0;
        ivFlow       = 8'd0;
        repeat (gap) tick();
    endtask

    task automatic run(input int age, input int flows[$], input bit hold_start);
        int d0, c0;
        exp_r     = model(age, flows);
        exp_valid = 1;
        d0 = done_cnt;
        c0 = ce_cnt;
        start_test(age);
        iStart = hold_start;
        for (int i = 0; i < flows.size(); i++) send(flows[i], $urandom_range(0, 2));
        iStart = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt != d0) break;
            tick();
        end
        check("done_pulses", done_cnt - d0, 1);
        check("ce_pulses", ce_cnt - c0, 1);
        tick();
    endtask

    task automatic zero_hold();
        hold_r = '0;
    endtask

    initial begin
        int fl[$];
        int d0;
        n_cmp = 0; n_bad = 0; done_cnt = 0; ce_cnt = 0; exp_valid = 0;
        hold_r = '0; exp_r = '0;
        iReset_n = 1'b0; iStart = 1'b0; iAbort = 1'b0; iSampleValid = 1'b0;
        ivEdad = '0; ivFlow = '0;
        #12;
        check("rst_busy", int'(oBusy), 0);
        check("rst_done", int'(oDone), 0);
        check("rst_ce", int'(oCVP_CE), 0);
        check("rst_edad", int'(ovEdad), 0);
        check("rst_vol", int'(ovVolumen), 0);
        check("rst_pct", int'(ovPorcentaje), 0);
        check("rst_cls", int'(ovClase), 0);
        check("rst_peak", int'(ovPicoFlujo), 0);
        iReset_n = 1'b1;
        repeat (2) tick();

        fl = {}; repeat (10) fl.push_back(40); repeat (8) fl.push_back(0);
        run(25, fl, 0);
        check("lit1_vol", int'(ovVolumen), 400);
        check("lit1_pct", int'(ovPorcentaje), 99);
        check("lit1_cls", int'(ovClase), 0);

        fl = {50, 50}; repeat (8) fl.push_back(0);
        run(70, fl, 1);
        check("lit2_vol", int'(ovVolumen), 100);
        check("lit2_pct", int'(ovPorcentaje), 66);
        check("lit2_cls", int'(ovClase), 1);

        fl = {}; repeat (4) fl.push_back(50); repeat (8) fl.push_back(0);
        run(18, fl, 0);
        check("lit3_vol", int'(ovVolumen), 200);
        check("lit3_pct", int'(ovPorcentaje), 52);
        check("lit3_cls", int'(ovClase), 2);

        fl = {}; repeat (17) fl.push_back(255); repeat (8) fl.push_back(0);
        run(5, fl, 0);
        check("lit4_vol", int'(ovVolumen), 4095);
        check("lit4_pct", int'(ovPorcentaje), 255);
        check("lit4_cls", int'(ovClase), 0);
`ifdef ESPIRO_PEAK_FLOW_EN
        check("lit4_peak", int'(ovPicoFlujo), 255);
`else
        check("lit4_peak", int'(ovPicoFlujo), 0);
`endif

        fl = {}; repeat (MAX_SAMP) fl.push_back(0);
        run(40, fl, 0);
        check("lit5_pct", int'(ovPorcentaje), 0);
        check("lit5_cls", int'(ovClase), 3);

        fl = {30, 30}; repeat (8) fl.push_back(0);
        run(99, fl, 0);
        check("lit6_vol", int'(ovVolumen), 60);
        check("lit6_cls", int'(ovClase), 3);

        // Abort during acquisition: no oDone, results cleared.
        exp_valid = 0;
        d0 = done_cnt;
        start_test(30);
        send(60, 0); send(70, 1);
        zero_hold();
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        check("abort_busy", int'(oBusy), 0);
        check("abort_vol", int'(ovVolumen), 0);
        repeat (30) tick();
        check("abort_no_done", done_cnt - d0, 0);

        // Abort and start together in IDLE: start refused.
        iStart = 1'b1; iAbort = 1'b1; ivEdad = 8'd44;
        tick();
        iStart = 1'b0; iAbort = 1'b0;
        check("abort_beats_start", int'(oBusy), 0);
        repeat (3) tick();

        // Reset while the divider is running.
        exp_valid = 0;
        start_test(25);
        for (int i = 0; i < 10; i++) send(40, 0);
        for (int i = 0; i < 8; i++) send(0, 0);
        repeat (3) tick();
        check("middiv_busy", int'(oBusy), 1);
        #2;
        iReset_n = 1'b0;
        zero_hold();
        #1;
        check("rst2_busy", int'(oBusy), 0);
        check("rst2_done", int'(oDone), 0);
        check("rst2_vol", int'(ovVolumen), 0);
        check("rst2_pct", int'(ovPorcentaje), 0);
        check("rst2_cls", int'(ovClase), 0);
        check("rst2_edad", int'(ovEdad), 0);
        check("rst2_peak", int'(ovPicoFlujo), 0);
        #1;
        iReset_n = 1'b1;
        repeat (25) tick();

        fl = {}; repeat (10) fl.push_back(40); repeat (8) fl.push_back(0);
        run(25, fl, 0);
        check("post_rst_pct", int'(ovPorcentaje), 99);

        for (int t = 0; t < 12; t++) begin
            int n;
            n = $urandom_range(1, 25);
            fl = {};
            fl.push_back($urandom_range(1, 255));
            for (int i = 1; i < n; i++)
                fl.push_back(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 200));
            repeat (8) fl.push_back(0);
            run($urandom_range(1, 90), fl, 0);
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
